// File: rtl/calc_arbiter.sv
// calc_arbiter
//   Round-robin arbiter that shares one calculator between two requesters.
//   A granted requester's op/operands are latched once at grant and then
//   presented to the calculator. Each transaction issues a one-cycle Go and
//   waits for Done, giving up after TIMEOUT cycles. It then returns a
//   one-cycle ack to the owner together with res/err.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req0/req1             level requests, held until acked
//   op0/op1, a0/b0, a1/b1 per-requester op code and operands
//   ack0/ack1             one-cycle completion pulse (RESP only)
//   res, err              result / timeout flag, valid while an ack is high
//   calc_go               one-cycle start pulse to the calculator
//   calc_op, calc_in1/2   registered op and operands to the calculator
//   calc_done, calc_out   calculator done strobe and result
//   state                 FSM state code (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   owner                 requester currently granted
module calc_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [2:0] res,
    output logic       err,
    output logic       calc_go,
    output logic [1:0] calc_op,
    output logic [2:0] calc_in1,
    output logic [2:0] calc_in2,
    input  logic       calc_done,
    input  logic [2:0] calc_out,
    output logic [1:0] state,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;    // requester served most recently
    logic       block_q, block_d;  // last_q is ineligible this IDLE cycle
    logic [7:0] cnt_q, cnt_d;
    logic       go_q, go_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [2:0] res_q, res_d;
    logic       err_q, err_d;
    logic [1:0] op_q, op_d;
    logic [2:0] in1_q, in1_d;
    logic [2:0] in2_q, in2_d;

    logic       elig0, elig1, grant;
    logic [7:0] cnt_inc;

    assign elig0   = req0 && !(block_q && !last_q);
    assign elig1   = req1 && !(block_q && last_q);
    // Contention goes to whoever was not served last; otherwise the sole requester.
    assign grant   = (elig0 && elig1) ? ~last_q : elig1;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        go_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        res_d   = res_q;
        err_d   = err_q;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;

        case (state_q)
            IDLE: begin
                block_d = 1'b0;
                if (elig0 || elig1) begin
                    owner_d = grant;
                    op_d    = grant ? op1 : op0;
                    in1_d   = grant ? a1 : a0;
                    in2_d   = grant ? b1 : b0;
                    go_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done is checked first so it wins over a simultaneous expiry.
                if (calc_done) begin
                    res_d   = calc_out;
                    err_d   = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT[7:0]) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        ack0_d  = ~owner_q;
                        ack1_d  = owner_q;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                last_d  = owner_q;
                block_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // makes requester 0 win the first contention
            block_q <= 1'b0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            block_q <= block_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            res_q   <= res_d;
            err_q   <= err_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    assign state    = state_q;
    assign owner    = owner_q;
    assign calc_go  = go_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign res      = res_q;
    assign err      = err_q;
    assign calc_op  = op_q;
    assign calc_in1 = in1_q;
    assign calc_in2 = in2_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter
//   Directed bench for calc_arbiter (TIMEOUT=15). Inputs change and outputs
//   are sampled 1 time unit after each rising edge.
module tb_calc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [2:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic [2:0] res;
    logic       err;
    logic       calc_go;
    logic [1:0] calc_op;
    logic [2:0] calc_in1, calc_in2;
    logic       calc_done;
    logic [2:0] calc_out;
    logic [1:0] state;
    logic       owner;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    calc_arbiter #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .ack0     (ack0),
        .ack1     (ack1),
        .res      (res),
        .err      (err),
        .calc_go  (calc_go),
        .calc_op  (calc_op),
        .calc_in1 (calc_in1),
        .calc_in2 (calc_in2),
        .calc_done(calc_done),
        .calc_out (calc_out),
        .state    (state),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        calc_done = 1'b0; calc_out = '0;
        tick(); tick();

        // Reset state
        check("rst_state", state, 0);
        check("rst_owner", owner, 0);
        check("rst_go",    calc_go, 0);
        check("rst_ack",   {ack0, ack1}, 0);
        check("rst_res",   res, 0);
        check("rst_err",   err, 0);
        check("rst_calc",  {calc_op, calc_in1, calc_in2}, 0);

        // Single request
        rst = 1'b0; req0 = 1'b1; op0 = 2'd2; a0 = 3'd3; b0 = 3'd5;
        tick();
        check("s_issue",  state, 1);
        check("s_go",     calc_go, 1);
        check("s_op",     calc_op, 2);
        check("s_in1",    calc_in1, 3);
        check("s_in2",    calc_in2, 5);
        check("s_owner",  owner, 0);
        a0 = 3'd7; op0 = 2'd1;       // operands must stay latched
        tick();
        check("s_wait",   state, 2);
        check("s_go_off", calc_go, 0);
        check("s_hold",   {calc_op, calc_in1}, {2'd2, 3'd3});
        tick();
        calc_done = 1'b1; calc_out = 3'd6;
        tick();
        check("s_resp",   state, 3);
        check("s_ack",    {ack0, ack1}, 2'b10);
        check("s_res",    res, 6);
        check("s_err",    err, 0);
        calc_done = 1'b0; req0 = 1'b0;
        tick();
        check("s_idle",   state, 0);
        check("s_ackoff", {ack0, ack1}, 0);

        // Contention from reset: 0 then 1; each drops req after its ack
        rst = 1'b1; tick(); rst = 1'b0;
        req0 = 1'b1; op0 = 2'd1; a0 = 3'd2; b0 = 3'd4;
        req1 = 1'b1; op1 = 2'd3; a1 = 3'd6; b1 = 3'd1;
        tick();
        check("c_owner0", owner, 0);
        check("c_calc0",  {calc_op, calc_in1, calc_in2}, {2'd1, 3'd2, 3'd4});
        check("c_go0",    calc_go, 1);
        tick();
        calc_done = 1'b1; calc_out = 3'd5;
        tick();
        check("c_ack0",   {ack0, ack1}, 2'b10);
        check("c_res0",   res, 5);
        calc_done = 1'b0;
        tick();
        check("c_idle0",  state, 0);
        tick();
        check("c_owner1", owner, 1);
        check("c_go1",    calc_go, 1);
        check("c_calc1",  {calc_op, calc_in1, calc_in2}, {2'd3, 3'd6, 3'd1});
        req0 = 1'b0;
        tick();
        calc_done = 1'b1; calc_out = 3'd2;
        tick();
        check("c_ack1",   {ack0, ack1}, 2'b01);
        check("c_res1",   res, 2);
        calc_done = 1'b0;
        tick();
        req1 = 1'b0;
        tick();
        check("c_quiet",  state, 0);

        // Fairness with both held high
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("f_issue", state, 1);
            check("f_owner", owner, i % 2);
            tick();
            calc_done = 1'b1; calc_out = 3'(i);
            tick();
            check("f_ack",   {ack0, ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check("f_res",   res, i);
            calc_done = 1'b0;
            tick();
            check("f_idle",  state, 0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Timeout: 15 WAIT cycles then err ack
        req0 = 1'b1;
        tick();
        check("t_owner",  owner, 0);
        tick();
        check("t_w1",     state, 2);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("t_wait", {state, ack0}, {2'd2, 1'b0});
        end
        tick();
        check("t_resp",   state, 3);
        check("t_ack",    {ack0, ack1}, 2'b10);
        check("t_err",    err, 1);
        check("t_res",    res, 0);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; op1 = 2'd0; a1 = 3'd1; b1 = 3'd1;
        tick();
        check("t2_owner", owner, 1);
        tick();
        calc_done = 1'b1; calc_out = 3'd7;
        tick();
        check("t2_ack",   {ack0, ack1}, 2'b01);
        check("t2_res",   {res, err}, {3'd7, 1'b0});
        calc_done = 1'b0; req1 = 1'b0;
        tick();

        // Done coincides with expiry: done wins
        req0 = 1'b1;
        tick();
        check("b_owner",  owner, 0);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("b_w15",    state, 2);
        calc_done = 1'b1; calc_out = 3'd4;
        tick();
        check("b_ack",    {ack0, ack1}, 2'b10);
        check("b_res",    {res, err}, {3'd4, 1'b0});
        calc_done = 1'b0; req0 = 1'b0;
        tick();

        // Done strobe in IDLE is ignored
        calc_done = 1'b1;
        tick();
        check("i_state",  state, 0);
        check("i_ack",    {ack0, ack1}, 0);
        calc_done = 1'b0;
        tick();
        check("i_state2", {state, ack0, ack1}, 0);

        // Reset mid-WAIT
        req1 = 1'b1;
        tick();
        check("r_owner",  owner, 1);
        tick();
        check("r_wait",   state, 2);
        rst = 1'b1;
        tick();
        check("r_all",    {state, owner, ack0, ack1, res, err, calc_go, calc_op, calc_in1, calc_in2}, 0);
        rst = 1'b0; req1 = 1'b0; calc_done = 1'b1; calc_out = 3'd5;
        tick();
        check("r_ignore", {state, ack0, ack1, res, err}, 0);
        calc_done = 1'b0; req0 = 1'b1; req1 = 1'b1;
        tick();
        check("r_grant",  {state, owner}, {2'd1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
